// File: rtl/regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb
// Multi-port register file with two synchronous write ports, NUM_RD
// combinational read ports, optional write-to-read forwarding, optional
// hardwired-zero r0 and a per-register busy scoreboard for hazard detection.
//
// Ports
//   clk      in   1               rising-edge clock
//   rst_n    in   1               asynchronous active-low reset (clears all state)
//   ra       in   NUM_RD*ADDR_W   read addresses, port i = ra[i*ADDR_W +: ADDR_W]
//   rd       out  NUM_RD*DATA_W   read data, port i = rd[i*DATA_W +: DATA_W]
//   rd_busy  out  NUM_RD          register on read port i has an outstanding write
//   we0      in   1               write port 0 enable
//   wa0      in   ADDR_W          write port 0 address
//   wd0      in   DATA_W          write port 0 data
//   we1      in   1               write port 1 enable (wins over port 0)
//   wa1      in   ADDR_W          write port 1 address
//   wd1      in   DATA_W          write port 1 data
//   iss_v    in   1               issue strobe, marks iss_a busy
//   iss_a    in   ADDR_W          destination register being issued
// -----------------------------------------------------------------------------
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       iss_v,
    input  logic [ADDR_W-1:0]          iss_a
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit LP_BYP  = (BYPASS != 0);
    localparam bit LP_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              w_wen0;
    logic              w_wen1;

    // Writes to r0 are discarded entirely when it is hardwired to zero.
    assign w_wen0 = we0 && !(LP_ZERO && (wa0 == '0));
    assign w_wen1 = we1 && !(LP_ZERO && (wa1 == '0));

    // Scoreboard next state: a new issue beats a same-cycle writeback, since
    // the freshly issued producer is the one the consumers must wait for.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int n = 0; n < DEPTH; n++) begin
            if (iss_v && (iss_a == ADDR_W'(n))) begin
                w_busy_nxt[n] = 1'b1;
            end else if ((we0 && (wa0 == ADDR_W'(n))) ||
                         (we1 && (wa1 == ADDR_W'(n)))) begin
                w_busy_nxt[n] = 1'b0;
            end
        end
        if (LP_ZERO) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    // Port 1 is assigned last so it wins an address collision with port 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wen0) begin
                r_mem[wa0] <= wd0;
            end
            if (w_wen1) begin
                r_mem[wa1] <= wd1;
            end
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic              w_hit0;
        logic              w_hit1;
        logic [DATA_W-1:0] w_data;

        assign w_a = ra[g*ADDR_W +: ADDR_W];

        // Forwarding is suppressed in reset so reads return zero there even
        // if a write port is being driven.
        assign w_hit0 = rst_n && we0 && (wa0 == w_a);
        assign w_hit1 = rst_n && we1 && (wa1 == w_a);

        always_comb begin
            w_data = r_mem[w_a];
            if (LP_BYP && w_hit1) begin
                w_data = wd1;
            end else if (LP_BYP && w_hit0) begin
                w_data = wd0;
            end
            if (LP_ZERO && (w_a == '0)) begin
                w_data = '0;
            end
        end

        assign rd[g*DATA_W +: DATA_W] = w_data;

        // With forwarding, the value on rd is already the produced result, so
        // the consumer need not stall even though the busy bit is still set.
        assign rd_busy[g] = r_busy[w_a] && !(LP_BYP && (w_hit0 || w_hit1));
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp_sb
// Drives two builds of regfile_mp_sb from the same inputs:
//   dut_a : BYPASS=1, ZERO_REG=1
//   dut_b : BYPASS=0, ZERO_REG=0
// Directed scenarios check against literal values; the random scenario checks
// against an array-based model of the register file and scoreboard.
// -----------------------------------------------------------------------------
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd_a, rd_b;
    logic [NR-1:0]     busy_a, busy_b;
    logic              we0, we1, iss_v;
    logic [AW-1:0]     wa0, wa1, iss_a;
    logic [DW-1:0]     wd0, wd1;

    int n_vec = 0;
    int n_err = 0;

    // model state: index 0 = dut_a build, 1 = dut_b build
    logic [DW-1:0] mdl_mem  [2][DEPTH];
    bit            mdl_busy [2][DEPTH];

    always #5 clk = ~clk;

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_a), .rd_busy(busy_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_v(iss_v), .iss_a(iss_a));

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_b), .rd_busy(busy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_v(iss_v), .iss_a(iss_a));

    function automatic logic [DW-1:0] get_rd(int v, int p);
        return (v == 0) ? rd_a[p*DW +: DW] : rd_b[p*DW +: DW];
    endfunction

    function automatic logic get_busy(int v, int p);
        return (v == 0) ? busy_a[p] : busy_b[p];
    endfunction

    function automatic int get_ra(int p);
        return int'(ra[p*AW +: AW]);
    endfunction

    task automatic set_ra(int p, int a);
        ra[p*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; iss_v = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_a = '0;
    endtask

    task automatic mdl_clear();
        for (int v = 0; v < 2; v++)
            for (int n = 0; n < DEPTH; n++) begin
                mdl_mem[v][n]  = '0;
                mdl_busy[v][n] = 1'b0;
            end
    endtask

    // Register-file behaviour at a clock edge, using the inputs held across it.
    task automatic mdl_step();
        if (!rst_n) begin
            mdl_clear();
            return;
        end
        for (int v = 0; v < 2; v++) begin
            bit z = (v == 0);
            if (we0 && !(z && wa0 == 0)) mdl_mem[v][wa0] = wd0;
            if (we1 && !(z && wa1 == 0)) mdl_mem[v][wa1] = wd1;
            for (int n = 0; n < DEPTH; n++) begin
                if (iss_v && iss_a == n && !(z && n == 0)) mdl_busy[v][n] = 1'b1;
                else if ((we0 && wa0 == n) || (we1 && wa1 == n)) mdl_busy[v][n] = 1'b0;
            end
        end
    endtask

    function automatic logic [DW-1:0] mdl_rd(int v, int a);
        bit byp = (v == 0);
        bit z   = (v == 0);
        if (!rst_n) return '0;
        if (z && a == 0) return '0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return mdl_mem[v][a];
    endfunction

    function automatic logic mdl_rd_busy(int v, int a);
        bit byp = (v == 0);
        bit wr  = (we0 && wa0 == a) || (we1 && wa1 == a);
        if (!rst_n) return 1'b0;
        return mdl_busy[v][a] && !(byp && wr);
    endfunction

    // Advance one clock; returns at posedge + 1.
    task automatic cycle();
        @(posedge clk);
        mdl_step();
        #1;
    endtask

    task automatic test_reset();
        idle();
        set_ra(0, 5); set_ra(1, 6); set_ra(2, 5);
        #1;
        n_vec++;
        if (rd_a[DW-1:0] !== 32'h0 || rd_b[DW-1:0] !== 32'h0) begin
            n_err++;
            $display("FAIL reset_initial_rd: a=%h b=%h required 0", rd_a[DW-1:0], rd_b[DW-1:0]);
        end
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
        iss_v = 1'b1; iss_a = 5'd6;
        cycle();
        idle();
        #1;
        n_vec++;
        if (get_rd(0, 0) !== 32'hDEAD_BEEF || get_rd(1, 0) !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL reset_prewrite: a=%h b=%h required deadbeef", get_rd(0, 0), get_rd(1, 0));
        end
        n_vec++;
        if (busy_a[1] !== 1'b1 || busy_b[1] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_prebusy: a=%b b=%b required 1", busy_a[1], busy_b[1]);
        end
        // assert reset mid-cycle, check with no clock edge
        #1;
        rst_n = 1'b0;
        mdl_clear();
        #1;
        n_vec++;
        if (rd_a !== '0 || rd_b !== '0) begin
            n_err++;
            $display("FAIL reset_rd: a=%h b=%h required 0", rd_a, rd_b);
        end
        n_vec++;
        if (busy_a !== '0 || busy_b !== '0) begin
            n_err++;
            $display("FAIL reset_busy: a=%b b=%b required 0", busy_a, busy_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_dual_write();
        idle();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h22;
        cycle();
        idle();
        set_ra(0, 3);
        #1;
        n_vec++;
        if (get_rd(0, 0) !== 32'h22 || get_rd(1, 0) !== 32'h22) begin
            n_err++;
            $display("FAIL dual_same_addr: a=%h b=%h required 22", get_rd(0, 0), get_rd(1, 0));
        end
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h22;
        cycle();
        idle();
        set_ra(0, 3); set_ra(1, 4);
        #1;
        n_vec++;
        if (get_rd(0, 0) !== 32'h11 || get_rd(1, 0) !== 32'h11) begin
            n_err++;
            $display("FAIL dual_r3: a=%h b=%h required 11", get_rd(0, 0), get_rd(1, 0));
        end
        n_vec++;
        if (get_rd(0, 1) !== 32'h22 || get_rd(1, 1) !== 32'h22) begin
            n_err++;
            $display("FAIL dual_r4: a=%h b=%h required 22", get_rd(0, 1), get_rd(1, 1));
        end
    endtask

    task automatic test_bypass();
        idle();
        set_ra(0, 7); set_ra(1, 7); set_ra(2, 3);
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hA5A5_0001;
        #1;
        n_vec++;
        if (get_rd(0, 0) !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL bypass_same_cycle: got %h required a5a50001", get_rd(0, 0));
        end
        n_vec++;
        if (get_rd(1, 0) !== 32'h0) begin
            n_err++;
            $display("FAIL nobypass_old_value: got %h required 0", get_rd(1, 0));
        end
        cycle();
        idle();
        #1;
        n_vec++;
        if (get_rd(0, 0) !== 32'hA5A5_0001 || get_rd(1, 0) !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL bypass_next_cycle: a=%h b=%h required a5a50001", get_rd(0, 0), get_rd(1, 0));
        end
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hA5A5_0002;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hA5A5_0003;
        #1;
        n_vec++;
        if (get_rd(0, 1) !== 32'hA5A5_0003 || get_rd(1, 1) !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL bypass_priority: a=%h b=%h required a5a50003/a5a50001", get_rd(0, 1), get_rd(1, 1));
        end
        we1 = 1'b0;
        #1;
        n_vec++;
        if (get_rd(0, 1) !== 32'hA5A5_0002) begin
            n_err++;
            $display("FAIL bypass_port0: got %h required a5a50002", get_rd(0, 1));
        end
        cycle();
        idle();
    endtask

    task automatic test_zero_reg();
        idle();
        set_ra(0, 0); set_ra(1, 0); set_ra(2, 0);
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        iss_v = 1'b1; iss_a = 5'd0;
        #1;
        n_vec++;
        if (get_rd(0, 0) !== 32'h0 || busy_a !== 3'b000) begin
            n_err++;
            $display("FAIL zero_same_cycle: rd=%h busy=%b required 0/000", get_rd(0, 0), busy_a);
        end
        cycle();
        idle();
        #1;
        n_vec++;
        if (get_rd(0, 2) !== 32'h0 || busy_a !== 3'b000) begin
            n_err++;
            $display("FAIL zero_next_cycle: rd=%h busy=%b required 0/000", get_rd(0, 2), busy_a);
        end
        n_vec++;
        if (get_rd(1, 0) !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL nonzero_r0_store: got %h required ffffffff", get_rd(1, 0));
        end
        // ordinary r0: issue and write together leaves it busy
        n_vec++;
        if (busy_b[0] !== 1'b1) begin
            n_err++;
            $display("FAIL nonzero_r0_busy: got %b required 1", busy_b[0]);
        end
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h0;
        cycle();
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        set_ra(0, 9); set_ra(1, 9); set_ra(2, 10);
        iss_v = 1'b1; iss_a = 5'd9;
        #1;
        n_vec++;
        if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sb_issue_same_cycle: a=%b b=%b required 0", busy_a[0], busy_b[0]);
        end
        cycle();
        idle();
        #1;
        n_vec++;
        if (busy_a[0] !== 1'b1 || busy_b[0] !== 1'b1 || busy_a[2] !== 1'b0) begin
            n_err++;
            $display("FAIL sb_issue: a=%b b=%b r10=%b required 1/1/0", busy_a[0], busy_b[0], busy_a[2]);
        end
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h42;
        #1;
        n_vec++;
        if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_write_same_cycle: a=%b b=%b required 0/1", busy_a[0], busy_b[0]);
        end
        cycle();
        idle();
        #1;
        n_vec++;
        if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b0 || get_rd(0, 0) !== 32'h42 || get_rd(1, 0) !== 32'h42) begin
            n_err++;
            $display("FAIL sb_cleared: busy a=%b b=%b rd a=%h b=%h required 0/0/42/42",
                     busy_a[0], busy_b[0], get_rd(0, 0), get_rd(1, 0));
        end
        iss_v = 1'b1; iss_a = 5'd9;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h43;
        cycle();
        idle();
        #1;
        n_vec++;
        if (busy_a[0] !== 1'b1 || busy_b[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_set_wins: a=%b b=%b required 1", busy_a[0], busy_b[0]);
        end
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h44;
        cycle();
        idle();
    endtask

    task automatic test_random();
        int ncyc = 10000;
        idle();
        rst_n = 1'b0;
        mdl_clear();
        cycle();
        rst_n = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            we0   = 1'($urandom_range(0, 1));
            we1   = 1'($urandom_range(0, 1));
            iss_v = ($urandom_range(0, 2) == 0);
            wa0   = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            wa1   = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            iss_a = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            wd0   = $urandom;
            wd1   = $urandom;
            for (int p = 0; p < NR; p++)
                set_ra(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                mdl_clear();
            end
            #1;
            for (int v = 0; v < 2; v++)
                for (int p = 0; p < NR; p++) begin
                    logic [DW-1:0] e_rd;
                    logic          e_bz;
                    e_rd = mdl_rd(v, get_ra(p));
                    e_bz = mdl_rd_busy(v, get_ra(p));
                    n_vec++;
                    if (get_rd(v, p) !== e_rd) begin
                        n_err++;
                        $display("FAIL rand_rd c=%0d dut=%0d port=%0d ra=%0d: got %h required %h",
                                 c, v, p, get_ra(p), get_rd(v, p), e_rd);
                    end
                    n_vec++;
                    if (get_busy(v, p) !== e_bz) begin
                        n_err++;
                        $display("FAIL rand_busy c=%0d dut=%0d port=%0d ra=%0d: got %b required %b",
                                 c, v, p, get_ra(p), get_busy(v, p), e_bz);
                    end
                end
            cycle();
            rst_n = 1'b1;
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        ra = '0;
        idle();
        mdl_clear();
        #12;
        rst_n = 1'b1;
        test_reset();
        test_dual_write();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
